// File: rtl/afe_spi_master.sv
// rtl/afe_spi_master.sv - dual-device AFE SPI write master with LE latch pulse
// Optional one-entry command holding register enabled by defining AFE_SPI_QUEUE_EN.
module afe_spi_master #(
  parameter int CLK_DIVISOR = 25,
  parameter int WORD_WIDTH  = 24,
  parameter int LE_TICKS    = 2
) (
  input  logic        sysClk,
  input  logic        sysReset_n,
  input  logic [31:0] sysGPIO_OUT,
  input  logic        csrStrobe,
  output logic [31:0] status,
  output logic [1:0]  AFE_SPI_CLK,
  output logic [1:0]  AFE_SPI_SDI,
  output logic [1:0]  AFE_SPI_LE
);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, GAP} state_t;

  state_t                state, state_nx;
  logic [7:0]            div_cnt;
  logic [7:0]            hp_cnt;
  logic                  tick, busy, accept, reload, store, drop;
  logic                  sclk_r, dev_sel, overrun, pending;
  logic [WORD_WIDTH-1:0] shift_reg, load_data;
  logic                  load_sel;
  logic [23:0]           last_word;
  logic                  sclk_bit, sdi_bit, le_bit;
  logic                  unused_cmd_bits;

  assign unused_cmd_bits = ^sysGPIO_OUT[30:WORD_WIDTH];

  assign busy = (state != IDLE);
  assign tick = busy && (div_cnt == 8'(CLK_DIVISOR - 1));

`ifdef AFE_SPI_QUEUE_EN
  logic [WORD_WIDTH-1:0] hold_data;
  logic                  hold_sel;

  // A command parked while busy is launched straight out of GAP; the IDLE term
  // covers a command parked on the very cycle the FSM dropped back to IDLE.
  assign reload    = pending && ((state == IDLE) || ((state == GAP) && tick));
  assign store     = csrStrobe && busy && !pending;
  assign load_data = reload ? hold_data : sysGPIO_OUT[WORD_WIDTH-1:0];
  assign load_sel  = reload ? hold_sel : sysGPIO_OUT[31];

  always_ff @(posedge sysClk or negedge sysReset_n) begin
    if (!sysReset_n) begin
      pending   <= 1'b0;
      hold_data <= '0;
      hold_sel  <= 1'b0;
    end else if (store) begin
      pending   <= 1'b1;
      hold_data <= sysGPIO_OUT[WORD_WIDTH-1:0];
      hold_sel  <= sysGPIO_OUT[31];
    end else if (reload) begin
      pending   <= 1'b0;
    end
  end
`else
  assign reload    = 1'b0;
  assign store     = 1'b0;
  assign pending   = 1'b0;
  assign load_data = sysGPIO_OUT[WORD_WIDTH-1:0];
  assign load_sel  = sysGPIO_OUT[31];
`endif

  assign accept = (state == IDLE) && csrStrobe && !pending;
  assign drop   = csrStrobe && !accept && !store;

  always_ff @(posedge sysClk or negedge sysReset_n) begin
    if (!sysReset_n) state <= IDLE;
    else             state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (accept || reload) state_nx = SHIFT;
      SHIFT: if (tick && (hp_cnt == 8'(2 * WORD_WIDTH - 1))) state_nx = LATCH;
      LATCH: if (tick && (hp_cnt == 8'(LE_TICKS - 1))) state_nx = GAP;
      GAP:   if (tick) state_nx = reload ? SHIFT : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge sysClk or negedge sysReset_n) begin
    if (!sysReset_n) begin
      div_cnt   <= '0;
      hp_cnt    <= '0;
      sclk_r    <= 1'b0;
      dev_sel   <= 1'b0;
      overrun   <= 1'b0;
      shift_reg <= '0;
      last_word <= '0;
    end else begin
      div_cnt <= (!busy || tick) ? 8'd0 : div_cnt + 8'd1;

      // Half-period count restarts on every state change so each phase counts from zero.
      if (!busy || (tick && (state_nx != state))) hp_cnt <= '0;
      else if (tick)                              hp_cnt <= hp_cnt + 8'd1;

      if (accept || reload) begin
        shift_reg <= load_data;
        dev_sel   <= load_sel;
        last_word <= 24'(load_data);
        sclk_r    <= 1'b0;
      end else if ((state == SHIFT) && tick) begin
        sclk_r <= ~sclk_r;
        // Advance data only on the falling transition so SDI is stable at every rise.
        if (sclk_r) shift_reg <= {shift_reg[WORD_WIDTH-2:0], 1'b0};
      end

      if (accept)    overrun <= 1'b0;
      else if (drop) overrun <= 1'b1;
    end
  end

  assign sclk_bit = sclk_r;
  assign sdi_bit  = (state == SHIFT) && shift_reg[WORD_WIDTH-1];
  assign le_bit   = (state == LATCH);

  assign AFE_SPI_CLK = dev_sel ? {sclk_bit, 1'b0} : {1'b0, sclk_bit};
  assign AFE_SPI_SDI = dev_sel ? {sdi_bit, 1'b0}  : {1'b0, sdi_bit};
  assign AFE_SPI_LE  = dev_sel ? {le_bit, 1'b0}   : {1'b0, le_bit};

  assign status = {busy, overrun, pending, 5'b0, last_word};

endmodule

// File: tb/tb_afe_spi_master.sv
// tb/tb_afe_spi_master.sv - directed checks of afe_spi_master (default and small configurations)
// Queue expectations follow AFE_SPI_QUEUE_EN.
module tb_afe_spi_master;

  logic        clk;
  logic        rst_n;
  logic        strobe;
  logic [31:0] gpio;
  logic        use_small;

  logic        strobe_d, strobe_s;
  logic [31:0] status_d, status_s;
  logic [1:0]  clk_d, sdi_d, le_d, clk_s, sdi_s, le_s;

  logic [31:0] m_status;
  logic [1:0]  m_clk, m_sdi, m_le;

  int checks = 0;
  int errors = 0;

  assign strobe_d = strobe & ~use_small;
  assign strobe_s = strobe & use_small;
  assign m_status = use_small ? status_s : status_d;
  assign m_clk    = use_small ? clk_s : clk_d;
  assign m_sdi    = use_small ? sdi_s : sdi_d;
  assign m_le     = use_small ? le_s : le_d;

  afe_spi_master u_dut (
    .sysClk      (clk),
    .sysReset_n  (rst_n),
    .sysGPIO_OUT (gpio),
    .csrStrobe   (strobe_d),
    .status      (status_d),
    .AFE_SPI_CLK (clk_d),
    .AFE_SPI_SDI (sdi_d),
    .AFE_SPI_LE  (le_d)
  );

  afe_spi_master #(.CLK_DIVISOR(2), .WORD_WIDTH(8), .LE_TICKS(1)) u_small (
    .sysClk      (clk),
    .sysReset_n  (rst_n),
    .sysGPIO_OUT (gpio),
    .csrStrobe   (strobe_s),
    .status      (status_s),
    .AFE_SPI_CLK (clk_s),
    .AFE_SPI_SDI (sdi_s),
    .AFE_SPI_LE  (le_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; returns one falling edge later with the strobe seen.
  task automatic pulse(input logic [31:0] cmd);
    gpio   = cmd;
    strobe = 1'b1;
    @(negedge clk);
    strobe = 1'b0;
  endtask

  task automatic watch(output int cyc, output int le_p);
    logic ple;
    ple  = 1'b0;
    cyc  = 0;
    le_p = 0;
    while (m_status[31] && cyc < 10000) begin
      cyc++;
      if ((|m_le) && !ple) le_p++;
      ple = |m_le;
      @(negedge clk);
    end
  endtask

  task automatic do_txn(input logic [31:0] cmd, output int busy_cyc, output int rises,
                        output int le_cyc, output int other, output int unstable,
                        output int first_rise, output logic first_sdi,
                        output logic [31:0] word);
    int   d;
    logic pclk, psdi;
    d = int'(cmd[31]);
    busy_cyc = 0; rises = 0; le_cyc = 0; other = 0; unstable = 0; first_rise = 0;
    word = 0; pclk = 1'b0; psdi = 1'b0;
    pulse(cmd);
    first_sdi = m_sdi[d];
    while (m_status[31] && busy_cyc < 10000) begin
      busy_cyc++;
      if (m_clk[d] && !pclk) begin
        rises++;
        if (first_rise == 0) first_rise = busy_cyc;
        word = {word[30:0], m_sdi[d]};
        if (m_sdi[d] !== psdi) unstable++;
      end
      if (m_le[d]) le_cyc++;
      if (m_clk[1-d] | m_sdi[1-d] | m_le[1-d]) other++;
      pclk = m_clk[d];
      psdi = m_sdi[d];
      @(negedge clk);
    end
  endtask

  int          busy_cyc, rises, le_cyc, other, unstable, first_rise, cyc, le_p;
  logic        first_sdi, le_seen, busy_seen;
  logic [31:0] word;

  initial begin
    rst_n = 1'b0; strobe = 1'b0; gpio = 32'h0; use_small = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_status", status_d, 32'h0);
    check("reset_lines", {26'b0, clk_d, sdi_d, le_d}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    do_txn(32'h00A5C3F1, busy_cyc, rises, le_cyc, other, unstable, first_rise, first_sdi, word);
    check("a_busy_cycles", busy_cyc, 1275);
    check("a_rises", rises, 24);
    check("a_word", word, 32'h00A5C3F1);
    check("a_le_cycles", le_cyc, 50);
    check("a_other_dev", other, 0);
    check("a_sdi_stable", unstable, 0);
    check("a_first_rise", first_rise, 26);
    check("a_first_sdi", {31'b0, first_sdi}, 1);
    check("a_status", m_status, 32'h00A5C3F1);

    do_txn(32'h7E5A0F0F, busy_cyc, rises, le_cyc, other, unstable, first_rise, first_sdi, word);
    check("hi_bits_word", word, 32'h005A0F0F);
    check("hi_bits_status", m_status, 32'h005A0F0F);
    check("hi_bits_other", other, 0);

`ifdef AFE_SPI_QUEUE_EN
    pulse(32'h00A5C3F1);
    repeat (99) @(negedge clk);
    pulse(32'h80ABCDEF);
    check("q_pending_set", m_status, 32'hA0A5C3F1);
    repeat (99) @(negedge clk);
    pulse(32'h00111111);
    check("q_third_dropped", m_status, 32'hE0A5C3F1);
    watch(cyc, le_p);
    check("q_busy_cycles", cyc, 2350);
    check("q_le_pulses", le_p, 2);
    check("q_after", m_status, 32'h40ABCDEF);
    pulse(32'h00000777);
    check("q_overrun_clear", m_status, 32'h80000777);
    watch(cyc, le_p);
`else
    pulse(32'h00A5C3F1);
    repeat (99) @(negedge clk);
    pulse(32'h80ABCDEF);
    check("ov_dropped", m_status, 32'hC0A5C3F1);
    watch(cyc, le_p);
    check("ov_busy_cycles", cyc, 1175);
    check("ov_le_pulses", le_p, 1);
    check("ov_after", m_status, 32'h40A5C3F1);
    pulse(32'h00000777);
    check("ov_clear", m_status, 32'h80000777);
    watch(cyc, le_p);
    pulse(32'h00000555);
    repeat (1274) @(negedge clk);
    pulse(32'h00000999);
    check("edge_strobe_dropped", m_status, 32'h40000555);
    watch(cyc, le_p);
    check("edge_stays_idle", cyc, 0);
`endif

    pulse(32'h00A5C3F1);
    repeat (598) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_lines", {26'b0, clk_d, sdi_d, le_d}, 32'h0);
    check("rst_status", status_d, 32'h0);
    le_seen = 1'b0; busy_seen = 1'b0;
    repeat (50) begin
      @(negedge clk);
      le_seen |= |le_d;
    end
    rst_n = 1'b1;
    repeat (200) begin
      @(negedge clk);
      le_seen   |= |le_d;
      busy_seen |= status_d[31];
    end
    check("rst_no_le", {31'b0, le_seen}, 0);
    check("rst_idle", {31'b0, busy_seen}, 0);

    do_txn(32'h80123456, busy_cyc, rises, le_cyc, other, unstable, first_rise, first_sdi, word);
    check("b_rises", rises, 24);
    check("b_word", word, 32'h00123456);
    check("b_le_cycles", le_cyc, 50);
    check("b_other_dev", other, 0);
    check("b_first_sdi", {31'b0, first_sdi}, 0);
    check("b_status", m_status, 32'h00123456);

    use_small = 1'b1;
    @(negedge clk);
    do_txn(32'h0000C3A5, busy_cyc, rises, le_cyc, other, unstable, first_rise, first_sdi, word);
    check("s_busy_cycles", busy_cyc, 36);
    check("s_rises", rises, 8);
    check("s_word", word, 32'h000000A5);
    check("s_le_cycles", le_cyc, 2);
    check("s_sdi_stable", unstable, 0);
    check("s_first_rise", first_rise, 3);
    check("s_other_dev", other, 0);
    check("s_status", m_status, 32'h000000A5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/afe_spi_master.md
AFE_SPI_MASTER -- requirements
Module: afe_spi_master

Interface
REQ-001 The block SHALL have parameter CLK_DIVISOR, default 25, meaning sysClk cycles per SCLK half-period; legal range 2..255.
REQ-002 The block SHALL have parameter WORD_WIDTH, default 24, meaning bits shifted per transaction; legal range 8..24.
REQ-003 The block SHALL have parameter LE_TICKS, default 2, meaning LE pulse length in SCLK half-periods; minimum 1.
REQ-004 The block SHALL have port sysClk, input, 1 bit: the single clock; all logic runs on it.
REQ-005 The block SHALL have port sysReset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port sysGPIO_OUT, input, 32 bits: command word; [WORD_WIDTH-1:0] is data (MSB first) and bit 31 is the device select.
REQ-007 The block SHALL have port csrStrobe, input, 1 bit: a one-cycle command write request.
REQ-008 The block SHALL have port status, output, 32 bits: bit31 busy, bit30 overrun, bit29 pending, [23:0] last word launched (zero-extended).
REQ-009 The block SHALL have port AFE_SPI_CLK, output, 2 bits: per-device SCLK; idle low.
REQ-010 The block SHALL have port AFE_SPI_SDI, output, 2 bits: per-device serial data.
REQ-011 The block SHALL have port AFE_SPI_LE, output, 2 bits: per-device latch enable; idle low, pulses high.

Function
REQ-012 FSM states SHALL be IDLE, SHIFT, LATCH and GAP; a half-period tick SHALL fire every CLK_DIVISOR cycles while the FSM is not in IDLE.
REQ-013 In IDLE, csrStrobe SHALL load the shift register, device select and status[23:0], then enter SHIFT on the next cycle with busy=1.
REQ-014 Timing: strobe at cycle N gives busy=1 and SDI = data MSB at N+1; the first SCLK rise occurs at N+1+CLK_DIVISOR.
REQ-015 SHIFT SHALL run for 2*WORD_WIDTH half-periods, with SCLK low then high alternately and SDI changing only on SCLK falling transitions (stable across every rising edge).
REQ-016 SHIFT SHALL produce exactly WORD_WIDTH rising edges per transaction, and SCLK SHALL be low on exit.
REQ-017 LATCH SHALL drive LE high on the selected device for LE_TICKS half-periods, with SCLK low and SDI low.
REQ-018 GAP SHALL hold all lines low for one half-period and then return to IDLE.
REQ-019 Busy SHALL stay high for exactly (2*WORD_WIDTH+LE_TICKS+1)*CLK_DIVISOR cycles, which is 1275 cycles at default parameters.
REQ-020 The unselected device SHALL hold CLK, SDI and LE at 0 throughout a transaction.
REQ-021 A csrStrobe while busy (and not queued per REQ-027) SHALL be dropped and SHALL set the sticky overrun bit; overrun SHALL clear when the next command is accepted from IDLE.
REQ-022 A csrStrobe on the same cycle the FSM returns to IDLE SHALL be treated as busy, i.e. dropped or queued.
REQ-023 Only data bits [WORD_WIDTH-1:0] SHALL be shifted; bits WORD_WIDTH..30 SHALL be ignored.

Reset
REQ-024 Asserting sysReset_n low SHALL immediately force all outputs to 0, the FSM to IDLE, the counters and holding register to clear, and status to 0.
REQ-025 A reset asserted mid-transaction SHALL abort the transaction with no LE pulse.
REQ-026 Operation SHALL resume on the first sysClk edge after reset deassertion, and the first command SHALL be accepted normally.

Configuration
REQ-027 With macro AFE_SPI_QUEUE_EN defined, the block SHALL include a one-entry holding register: a strobe while busy with the register empty SHALL store the command and set pending=1.
REQ-028 With AFE_SPI_QUEUE_EN defined, a strobe while the holding register is full SHALL be dropped and SHALL set overrun, leaving the held command intact.
REQ-029 With AFE_SPI_QUEUE_EN defined, GAP exit with pending=1 SHALL load the held command and enter SHIFT on the next cycle, clearing pending, with no IDLE cycle in between.
REQ-030 Without AFE_SPI_QUEUE_EN, the block SHALL have no holding register, pending SHALL read 0, and all busy strobes SHALL follow REQ-021.

Verification
REQ-031 Defaults, strobe 0x00A5C3F1 (device 0) -> 24 SCLK rises on CLK[0]; SDI bits sampled on rises read 0xA5C3F1; LE[0] high for 50 cycles; busy high for 1275 cycles; device 1 lines stay 0.
REQ-032 Strobe 0x80123456 -> traffic only on device 1; status[23:0]=0x123456.
REQ-033 Queue off: second strobe 100 cycles after the first -> dropped, overrun=1, a single LE pulse; the next idle strobe clears overrun.
REQ-034 Queue on: three strobes during one transaction -> second sent back-to-back (busy never drops), third dropped, overrun=1, pending 1->0 at reload.
REQ-035 sysReset_n low at cycle 600 of a transaction -> all outputs 0 within the same cycle, no LE pulse, status=0.
REQ-036 CLK_DIVISOR=2, WORD_WIDTH=8, LE_TICKS=1 -> busy for 36 cycles, 8 rises, and SDI stable across each rise.
